// File: rtl/protocol_resp_framer.sv
// protocol_resp_framer
//   Serializes one sensor-protocol response into a byte stream for the UART
//   transmitter. The stream is: header, status, sensor address, command,
//   DATA_BYTES payload bytes (MSB first), an optional XOR checksum, then the
//   footer.
//
// Parameters
//   DATA_BYTES  - payload bytes per frame (1..16)
//   HEADER      - first byte of every frame
//   FOOTER      - last byte of every frame
//   CHECKSUM_EN - nonzero inserts XOR(status, addr, cmd, data) before footer
//
// Ports
//   clk          - clock, rising edge
//   reset        - asynchronous reset, active low
//   req_valid    - response fields valid        (in)
//   req_ready    - block idle, can take a frame (out)
//   status       - status byte                  (in)
//   sensor_addr  - sensor address byte          (in)
//   command      - command echo byte            (in)
//   data         - payload, top byte sent first (in)
//   out_valid    - out_byte valid               (out)
//   out_ready    - downstream accepts out_byte  (in)
//   out_byte     - current stream byte          (out)
//   out_last     - high with the footer byte    (out)
//   busy         - frame in progress            (out)
//   frame_count  - completed frames, wrapping   (out)
module protocol_resp_framer #(
  parameter int          DATA_BYTES  = 2,
  parameter logic [7:0]  HEADER      = 8'hFF,
  parameter logic [7:0]  FOOTER      = 8'h7F,
  parameter int          CHECKSUM_EN = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [7:0]              status,
  input  logic [7:0]              sensor_addr,
  input  logic [7:0]              command,
  input  logic [8*DATA_BYTES-1:0] data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_byte,
  output logic                    out_last,
  output logic                    busy,
  output logic [15:0]             frame_count
);

  if (DATA_BYTES < 1 || DATA_BYTES > 16) begin : g_param_check
    $error("protocol_resp_framer: DATA_BYTES must be in 1..16");
  end

  localparam logic [4:0] LAST_IDX = 5'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_STATUS,
    S_ADDR,
    S_CMD,
    S_DATA,
    S_CHK,
    S_FOOTER
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [7:0]              status_q;
  logic [7:0]              addr_q;
  logic [7:0]              cmd_q;
  logic [8*DATA_BYTES-1:0] data_q;
  logic [4:0]              idx;
  logic [7:0]              chk;
  logic                    accept;
  logic                    xfer;

  assign accept    = (state == S_IDLE) && req_valid;
  assign out_valid = (state != S_IDLE);
  assign xfer      = out_valid && out_ready;
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_last  = (state == S_FOOTER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Every non-idle state holds until its byte is taken downstream.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (req_valid) next_state = S_HEADER;
      S_HEADER: if (out_ready) next_state = S_STATUS;
      S_STATUS: if (out_ready) next_state = S_ADDR;
      S_ADDR:   if (out_ready) next_state = S_CMD;
      S_CMD:    if (out_ready) next_state = S_DATA;
      S_DATA: begin
        if (out_ready && (idx == LAST_IDX)) begin
          next_state = (CHECKSUM_EN != 0) ? S_CHK : S_FOOTER;
        end
      end
      S_CHK:    if (out_ready) next_state = S_FOOTER;
      S_FOOTER: if (out_ready) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Output byte is decoded from state and the latched copy of the request,
  // so it never depends on out_ready.
  always_comb begin
    out_byte = 8'h00;
    case (state)
      S_HEADER: out_byte = HEADER;
      S_STATUS: out_byte = status_q;
      S_ADDR:   out_byte = addr_q;
      S_CMD:    out_byte = cmd_q;
      S_DATA:   out_byte = data_q[8*DATA_BYTES-1 -: 8];
      S_CHK:    out_byte = chk;
      S_FOOTER: out_byte = FOOTER;
      default:  out_byte = 8'h00;
    endcase
  end

  // Payload is kept in a shift register: the byte on the wire is always the
  // top byte, and each accepted data byte shifts the next one up. The
  // checksum accumulates the field bytes as they are handed off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q    <= 8'h00;
      addr_q      <= 8'h00;
      cmd_q       <= 8'h00;
      data_q      <= '0;
      idx         <= 5'd0;
      chk         <= 8'h00;
      frame_count <= 16'h0000;
    end else if (accept) begin
      status_q <= status;
      addr_q   <= sensor_addr;
      cmd_q    <= command;
      data_q   <= data;
      idx      <= 5'd0;
      chk      <= 8'h00;
    end else if (xfer) begin
      case (state)
        S_STATUS, S_ADDR, S_CMD: chk <= chk ^ out_byte;
        S_DATA: begin
          chk    <= chk ^ out_byte;
          data_q <= data_q << 8;
          idx    <= idx + 5'd1;
        end
        S_FOOTER: frame_count <= frame_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_protocol_resp_framer.sv
// tb_protocol_resp_framer
//   Directed bench for protocol_resp_framer. Three instances are built:
//   defaults, checksum enabled, and four data bytes. A selector routes the
//   active instance's outputs to a common set of observation signals.
module tb_protocol_resp_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        out_ready;
  logic [7:0]  status;
  logic [7:0]  sensorAddr;
  logic [7:0]  command;
  logic [15:0] data16;
  logic [31:0] data32;
  logic        rvA, rvC, rvW;

  logic        rrA, ovA, olA, bsA;
  logic [7:0]  obA;
  logic [15:0] cntA;
  logic        rrC, ovC, olC, bsC;
  logic [7:0]  obC;
  logic [15:0] cntC;
  logic        rrW, ovW, olW, bsW;
  logic [7:0]  obW;
  logic [15:0] cntW;

  protocol_resp_framer dutA (
    .clk(clk), .reset(reset),
    .req_valid(rvA), .req_ready(rrA),
    .status(status), .sensor_addr(sensorAddr), .command(command), .data(data16),
    .out_valid(ovA), .out_ready(out_ready), .out_byte(obA), .out_last(olA),
    .busy(bsA), .frame_count(cntA)
  );

  protocol_resp_framer #(.CHECKSUM_EN(1)) dutC (
    .clk(clk), .reset(reset),
    .req_valid(rvC), .req_ready(rrC),
    .status(status), .sensor_addr(sensorAddr), .command(command), .data(data16),
    .out_valid(ovC), .out_ready(out_ready), .out_byte(obC), .out_last(olC),
    .busy(bsC), .frame_count(cntC)
  );

  protocol_resp_framer #(.DATA_BYTES(4)) dutW (
    .clk(clk), .reset(reset),
    .req_valid(rvW), .req_ready(rrW),
    .status(status), .sensor_addr(sensorAddr), .command(command), .data(data32),
    .out_valid(ovW), .out_ready(out_ready), .out_byte(obW), .out_last(olW),
    .busy(bsW), .frame_count(cntW)
  );

  int          sel;
  logic        curReqReady, curValid, curLast, curBusy;
  logic [7:0]  curByte;
  logic [15:0] curCount;

  // Route the selected instance to the observation signals.
  always_comb begin
    curReqReady = rrA; curValid = ovA; curLast = olA;
    curBusy = bsA; curByte = obA; curCount = cntA;
    case (sel)
      1: begin
        curReqReady = rrC; curValid = ovC; curLast = olC;
        curBusy = bsC; curByte = obC; curCount = cntC;
      end
      2: begin
        curReqReady = rrW; curValid = ovW; curLast = olW;
        curBusy = bsW; curByte = obW; curCount = cntW;
      end
      default: ;
    endcase
  end

  int checks;
  int failures;
  logic [7:0] expQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Present one request to the selected instance for exactly one edge.
  task automatic applyStimulus(input logic [7:0] st, input logic [7:0] ad,
                               input logic [7:0] cm, input logic [31:0] d);
    @(negedge clk);
    status     = st;
    sensorAddr = ad;
    command    = cm;
    data16     = d[15:0];
    data32     = d;
    checkOutput("req_ready_idle", 32'(curReqReady), 32'd1);
    case (sel)
      0: rvA = 1'b1;
      1: rvC = 1'b1;
      default: rvW = 1'b1;
    endcase
    @(posedge clk);
    #1;
    rvA = 1'b0;
    rvC = 1'b0;
    rvW = 1'b0;
  endtask

  // Walk the frame in expQ; with bp set out_ready follows 1,0,0,1,...
  // With midReq set, fields change and a new request is raised mid-frame.
  task automatic streamFrame(input int expCount, input bit bp, input bit midReq);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    while (k < expQ.size() && cyc < 200) begin
      @(negedge clk);
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (midReq && cyc == 1) begin
        status = 8'hFF;
        data16 = 16'h0000;
        rvA    = 1'b1;
      end
      checkOutput("out_valid", 32'(curValid), 32'd1);
      checkOutput("req_ready_busy", 32'(curReqReady), 32'd0);
      checkOutput("busy", 32'(curBusy), 32'd1);
      checkOutput($sformatf("byte%0d", k), 32'(curByte), 32'(expQ[k]));
      checkOutput("out_last", 32'(curLast), 32'(k == expQ.size() - 1));
      if (curValid && out_ready) k++;
      cyc++;
    end
    if (k != expQ.size()) checkOutput("stream_timeout", k, expQ.size());
    if (!bp) checkOutput("cycles", cyc, expQ.size());
    @(negedge clk);
    checkOutput("frame_count", 32'(curCount), expCount);
    checkOutput("busy_after", 32'(curBusy), 32'd0);
    checkOutput("req_ready_after", 32'(curReqReady), 32'd1);
    checkOutput("out_valid_after", 32'(curValid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    sel = 0;
    rvA = 1'b0; rvC = 1'b0; rvW = 1'b0;
    out_ready = 1'b0;
    status = 8'h00; sensorAddr = 8'h00; command = 8'h00;
    data16 = 16'h0000; data32 = 32'h0;

    // Reset values of every instance.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkOutput("rst_req_ready", 32'(curReqReady), 32'd1);
      checkOutput("rst_out_valid", 32'(curValid), 32'd0);
      checkOutput("rst_out_byte", 32'(curByte), 32'h00);
      checkOutput("rst_out_last", 32'(curLast), 32'd0);
      checkOutput("rst_busy", 32'(curBusy), 32'd0);
      checkOutput("rst_frame_count", 32'(curCount), 32'd0);
    end
    reset = 1'b1;

    // Default instance: basic frame.
    sel = 0;
    $display("[TB] basic frame");
    expQ = '{8'hFF, 8'h00, 8'h12, 8'h03, 8'hAB, 8'hCD, 8'h7F};
    applyStimulus(8'h00, 8'h12, 8'h03, 32'h0000ABCD);
    streamFrame(1, 1'b0, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(8'h00, 8'h12, 8'h03, 32'h0000ABCD);
    streamFrame(2, 1'b1, 1'b0);

    // Fields change after acceptance and a request is held mid-frame.
    $display("[TB] field capture and request blocking");
    applyStimulus(8'h00, 8'h12, 8'h03, 32'h0000ABCD);
    streamFrame(3, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rvA = 1'b0;
    expQ = '{8'hFF, 8'hFF, 8'h12, 8'h03, 8'h00, 8'h00, 8'h7F};
    streamFrame(4, 1'b0, 1'b0);

    $display("[TB] reset abort");
    applyStimulus(8'h00, 8'h12, 8'h03, 32'h0000ABCD);
    repeat (5) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    checkOutput("pre_abort_byte", 32'(curByte), 32'hAB);
    reset = 1'b0;
    #1;
    checkOutput("abort_out_valid", 32'(curValid), 32'd0);
    checkOutput("abort_frame_count", 32'(curCount), 32'd0);
    checkOutput("abort_busy", 32'(curBusy), 32'd0);
    checkOutput("abort_out_last", 32'(curLast), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    expQ = '{8'hFF, 8'h00, 8'h12, 8'h03, 8'hAB, 8'hCD, 8'h7F};
    applyStimulus(8'h00, 8'h12, 8'h03, 32'h0000ABCD);
    streamFrame(1, 1'b0, 1'b0);

    // Checksum instance.
    sel = 1;
    $display("[TB] checksum frames");
    expQ = '{8'hFF, 8'h00, 8'h12, 8'h03, 8'hAB, 8'hCD, 8'h77, 8'h7F};
    applyStimulus(8'h00, 8'h12, 8'h03, 32'h0000ABCD);
    streamFrame(1, 1'b0, 1'b0);
    expQ = '{8'hFF, 8'h81, 8'h42, 8'h10, 8'h55, 8'hAA, 8'h2C, 8'h7F};
    applyStimulus(8'h81, 8'h42, 8'h10, 32'h000055AA);
    streamFrame(2, 1'b1, 1'b0);

    // Four-byte instance and counter wrap.
    sel = 2;
    $display("[TB] width and wrap");
    expQ = '{8'hFF, 8'h5A, 8'h34, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 8'h7F};
    applyStimulus(8'h5A, 8'h34, 8'h07, 32'h01020304);
    streamFrame(1, 1'b0, 1'b0);
    @(negedge clk);
    force dutW.frame_count = 16'hFFFF;
    @(negedge clk);
    release dutW.frame_count;
    #1;
    checkOutput("preload_count", 32'(curCount), 32'hFFFF);
    applyStimulus(8'h5A, 8'h34, 8'h07, 32'h01020304);
    streamFrame(0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
